// File: rtl/bitlogic_pkg.sv
// Shared definitions for the chunked bitwise-logic sequencer: op encoding and FSM state type.
package bitlogic_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bitlogic_slice.sv
// Combinational CHUNK-wide bitwise operator; one slice of the result per cycle.
module bitlogic_slice
    import bitlogic_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  op_t              op,
    output logic [CHUNK-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/bitlogic_seq.sv
// Sequential bitwise-logic unit: applies op to latched A/B one CHUNK per cycle.
// Optional result-is-zero flag enabled by defining BITLOGIC_ZERO_FLAG_EN.
//
// state  | meaning
// S_IDLE | waiting for start; out/zero hold last result
// S_RUN  | writing one result slice per cycle, idx = slice being written
// S_DONE | single-cycle completion pulse, then back to S_IDLE
module bitlogic_seq
    import bitlogic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;
    op_t              op_l;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] y_sl;
    logic [WIDTH-1:0] out_next;

    assign a_sl = a_l[int'(idx)*CHUNK +: CHUNK];
    assign b_sl = b_l[int'(idx)*CHUNK +: CHUNK];

    bitlogic_slice #(.CHUNK(CHUNK)) u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .op (op_l),
        .y  (y_sl)
    );

    // Result with the current slice merged in; also feeds the zero flag.
    always_comb begin
        out_next = out;
        out_next[int'(idx)*CHUNK +: CHUNK] = y_sl;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            a_l   <= '0;
            b_l   <= '0;
            op_l  <= OP_AND;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_l   <= A;
                        b_l   <= B;
                        op_l  <= op_t'(op);
                        out   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    out <= out_next;
                    if (idx == IDX_LAST) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BITLOGIC_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (reset)
            zero <= 1'b0;
        else if (state == S_IDLE && start)
            zero <= 1'b0;
        else if (state == S_RUN && idx == IDX_LAST)
            zero <= (out_next == '0);
    end
`else
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_bitlogic_seq.sv
// Self-checking bench for bitlogic_seq: cycle-indexed reference model plus directed literal checks.
module tb_bitlogic_seq;

    localparam int W = 32;
    localparam int C = 8;
    localparam int N = W / C;
`ifdef BITLOGIC_ZERO_FLAG_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0, B = '0;
    logic [31:0] out;
    logic        busy, done, zero;

    logic [15:0] a16 = '0, b16 = '0, out16;
    logic        busy16, done16, zero16;
    logic [63:0] a64 = '0, b64 = '0, out64;
    logic        busy64, done64, zero64;

    bitlogic_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .out(out), .busy(busy), .done(done), .zero(zero));

    bitlogic_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(a16), .B(b16),
        .out(out16), .busy(busy16), .done(done16), .zero(zero16));

    bitlogic_seq #(.WIDTH(64), .CHUNK(4)) dut64 (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(a64), .B(b64),
        .out(out64), .busy(busy64), .done(done64), .zero(zero64));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    function automatic logic [31:0] low_mask(input int nbits);
        logic [63:0] m;
        m = (64'd1 << nbits) - 64'd1;
        return m[31:0];
    endfunction

    // Reference model: an accepted operation is remembered by its accept cycle
    // and full result; all outputs are then a function of cycles elapsed.
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_t = 0;
    logic [31:0] m_full = '0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
        end else if (start && !(m_active && cyc <= m_t + N + 1)) begin
            m_active = 1'b1;
            m_t      = cyc;
            m_full   = 32'(ref_op(op, 64'(A), 64'(B)));
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        int          k;
        logic [31:0] e_out;
        bit          e_busy, e_done, e_zero;
        if (chk_en) begin
            k = cyc - m_t;
            e_out = '0; e_busy = 1'b0; e_done = 1'b0; e_zero = 1'b0;
            if (m_active) begin
                if (k <= N) begin
                    e_out  = m_full & low_mask((k - 1) * C);
                    e_busy = 1'b1;
                end else begin
                    e_out  = m_full;
                    e_busy = (k == N + 1);
                    e_done = (k == N + 1);
                    e_zero = ZF && (m_full == 32'd0);
                end
            end
            check("model_out",  64'(out),  64'(e_out));
            check("model_busy", 64'(busy), 64'(e_busy));
            check("model_done", 64'(done), 64'(e_done));
            check("model_zero", 64'(zero), 64'(e_zero));
        end
    end

    // Issue one start from IDLE and check latency and final result.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(N + 1));
        check({name, "_out"}, 64'(out), 64'(exp));
    endtask

    initial begin
        int dcount;
        int d16, d64, n;
        logic [15:0] e16;
        logic [63:0] e64;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_out",  64'(out),  64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_zero", 64'(zero), 64'd0);

        run_op("default_and", 2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
        run_op("op_and", 2'b00, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_0000);
        run_op("op_or",  2'b01, 32'hAAAA_5555, 32'hFFFF_0000, 32'hFFFF_5555);
        run_op("op_xor", 2'b10, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        run_op("op_nor", 2'b11, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0000_AAAA);

        run_op("zero_xor", 2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000);
        check("zero_at_done", 64'(zero), 64'(ZF));
        @(negedge clk);
        check("zero_held", 64'(zero), 64'(ZF));
        run_op("zero_or", 2'b01, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
        check("zero_cleared", 64'(zero), 64'd0);

        // Reset during the second RUN cycle discards the partial result.
        @(negedge clk);
        op = 2'b01; A = 32'hFFFF_FFFF; B = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrun_reset_out",  64'(out),  64'd0);
        check("midrun_reset_busy", 64'(busy), 64'd0);
        dcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midrun_reset_nodone", 64'(dcount), 64'd0);
        run_op("after_reset", 2'b10, 32'h0F0F_0F0F, 32'hFF00_FF00, 32'hF00F_F00F);

        // Start held high with operands changing every cycle.
        @(negedge clk);
        A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3)); start = 1'b1;
        dcount = 0;
        repeat (36) begin
            @(negedge clk);
            if (done) dcount++;
            A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
        end
        start = 1'b0;
        check("held_start_dones", 64'(dcount), 64'd6);
        repeat (8) @(negedge clk);

        // Randomized traffic including occasional resets and forced-zero results.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 59) == 0);
            op    = 2'($urandom_range(0, 3));
            A     = $urandom;
            B     = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                B  = A;
                op = 2'b10;
            end
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Alternate geometries: N=1 and N=16.
        @(negedge clk);
        op = 2'b00; A = $urandom;
        a16 = 16'($urandom); b16 = 16'($urandom);
        a64 = {32'($urandom), 32'($urandom)}; b64 = {32'($urandom), 32'($urandom)};
        e16 = a16 & b16;
        e64 = a64 & b64;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a16 = '0; b16 = '0; a64 = '0; b64 = '0;
        d16 = -1; d64 = -1;
        n = 1;
        while ((d16 < 0 || d64 < 0) && n < 30) begin
            if (done16 && d16 < 0) d16 = n;
            if (done64 && d64 < 0) d64 = n;
            @(negedge clk);
            n++;
        end
        check("n1_latency",  64'(d16), 64'd2);
        check("n16_latency", 64'(d64), 64'd17);
        check("n1_out",  64'(out16), 64'(e16));
        check("n16_out", out64, e64);
        check("n1_zero",  64'(zero16), 64'(ZF && (e16 == 16'd0)));
        check("n16_zero", 64'(zero64), 64'(ZF && (e64 == 64'd0)));
        @(negedge clk);
        check("n1_busy_idle",  64'(busy16), 64'd0);
        check("n16_busy_idle", 64'(busy64), 64'd0);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bitlogic_seq.md
BITLOGIC_SEQ -- requirements
Module: bitlogic_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, the bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, with N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 The block SHALL have port op, input, 2 bits: operation select (00 AND, 01 OR, 10 XOR, 11 NOR).
REQ-007 The block SHALL have ports A and B, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port out, output, WIDTH bits: the result register.
REQ-009 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port zero, output, 1 bit: result-is-zero flag (see Configuration).

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch A, B and op, clear out to 0, set chunk index to 0 and enter RUN.
REQ-014 In RUN, each cycle SHALL write out[idx*CHUNK +: CHUNK] = op(A_l, B_l) for that slice and increment idx, entering DONE after the slice idx = N-1 is written.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-016 Latency: for start sampled in cycle 0, RUN SHALL occupy cycles 1..N and done SHALL be high in cycle N+1 (cycle 5 at the defaults).
REQ-017 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-018 start SHALL be ignored in RUN and DONE; no queuing; latched operands are unaffected.
REQ-019 Changes on A, B or op after acceptance SHALL NOT affect the result in progress.
REQ-020 out SHALL hold its final value from DONE until the next accepted start.
REQ-021 The index counter SHALL be ceil(log2(N)) bits wide, minimum 1, and SHALL NOT wrap past N-1.
REQ-022 A start in the same cycle as done SHALL be ignored; start in the following IDLE cycle SHALL be accepted.

Reset
REQ-023 reset=1 SHALL force state IDLE, out=0, busy=0, done=0, zero=0, idx=0, and latched operands=0 on the next edge.
REQ-024 reset SHALL take priority over start and over any in-progress RUN; a partial result SHALL be discarded and no done SHALL be issued.

Configuration
REQ-025 With macro BITLOGIC_ZERO_FLAG_EN defined, zero SHALL be registered as (out == 0) at DONE entry and held until the next accepted start or reset, which clears it to 0.
REQ-026 Without BITLOGIC_ZERO_FLAG_EN, zero SHALL be tied to 0 and no comparison logic SHALL be built; all other behaviour SHALL be unchanged.

Structure
REQ-027 Package bitlogic_pkg SHALL hold the op encoding (OP_AND, OP_OR, OP_XOR, OP_NOR) and the FSM state type.
REQ-028 The combinational CHUNK-wide slice SHALL be sub-module bitlogic_slice (inputs a, b, op; output y), instantiated once and fed by a slice mux.
REQ-029 The top level SHALL contain only the FSM, index counter, operand latches and result register.

Verification
REQ-030 Defaults: A=0xF0F0_1234, B=0x0FF0_FFFF, op=00, start pulse -> done in cycle 5, out=0x00F0_1234, busy high in cycles 1-5.
REQ-031 Each op with A=0xAAAA_5555, B=0xFFFF_0000 -> AND 0xAAAA_0000, OR 0xFFFF_5555, XOR 0x5555_5555, NOR 0x0000_AAAA.
REQ-032 Start held high continuously plus operand changes mid-RUN -> exactly one done per 6 cycles; each result matches operands at its accept cycle.
REQ-033 reset asserted in cycle 2 of RUN -> out=0, busy=0 next cycle, no done pulse; a fresh start afterwards completes normally.
REQ-034 With BITLOGIC_ZERO_FLAG_EN: A=0x1234_5678, B=0x1234_5678, op=10 -> out=0, zero=1 at done; then op=01 -> zero=0. Without the macro, zero stays 0.
REQ-035 WIDTH=16, CHUNK=16 (N=1) and WIDTH=64, CHUNK=4 (N=16) -> done in cycles 2 and 17 respectively, with correct AND results.
